// File: rtl/ifetch_prefetch_unit_if.sv
// ifetch_prefetch_unit_if: handshake bundle that joins the fetch unit to the
// instruction memory, the redirect source (EX/MEM) and the IF/ID register.
// master = fetch unit side, slave = environment side.
interface ifetch_prefetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus1;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus1,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus1,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/ifetch_prefetch_unit.sv
// ifetch_prefetch_unit: instruction-fetch front end. Owns the fetch PC, issues
// word-addressed requests under a credit scheme that reserves a FIFO slot for
// every live response, buffers returns in an in-order prefetch FIFO and hands
// {instr, pc, pc+1} to IF/ID. A redirect flushes the FIFO and marks every
// in-flight response as stale.
// Optional macro IFETCH_BYPASS_EN: a response arriving while the FIFO is empty
// and nothing is stale is presented to IF/ID in the same cycle.
module ifetch_prefetch_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'd0
) (
  input logic             clk,
  input logic             reset_n,
  ifetch_prefetch_unit_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t             state;
  logic               req_q;
  logic [31:0]        fetch_pc;
  logic [31:0]        ret_pc;
  logic [OUT_W-1:0]   outstanding;
  logic [OUT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  entry_t             fifo_q [DEPTH];

  logic               issue_c;
  logic               drop_hit_c;
  logic               live_c;
  logic               bypass_c;
  logic               bypass_take_c;
  logic               push_c;
  logic               pop_c;
  logic               credit_c;
  logic [OUT_W-1:0]   out_n_c;
  logic [OUT_W-1:0]   drop_n_c;
  logic [CNT_W-1:0]   count_n_c;
  entry_t             head_c;

  // Next-cycle bookkeeping: issue/return/drop accounting and the credit check.
  always_comb begin
    issue_c       = req_q & bus.imem_gnt;
    drop_hit_c    = bus.imem_rvalid & (drop_cnt != '0);
    live_c        = bus.imem_rvalid & (drop_cnt == '0) & ~bus.redirect_valid;
`ifdef IFETCH_BYPASS_EN
    bypass_c      = live_c & (count == '0);
`else
    bypass_c      = 1'b0;
`endif
    bypass_take_c = bypass_c & bus.id_ready;
    push_c        = live_c & ~bypass_take_c;
    pop_c         = (count != '0) & bus.id_ready & ~bus.redirect_valid;

    out_n_c   = outstanding + OUT_W'(issue_c) - OUT_W'(bus.imem_rvalid);
    // After a redirect every response still in flight belongs to the old path.
    drop_n_c  = bus.redirect_valid ? out_n_c : (drop_cnt - OUT_W'(drop_hit_c));
    count_n_c = bus.redirect_valid ? '0 : (count + CNT_W'(push_c) - CNT_W'(pop_c));

    credit_c  = (32'(out_n_c) < MAX_OUTSTANDING) &&
                ((32'(count_n_c) + 32'(out_n_c) - 32'(drop_n_c)) < DEPTH);
  end

  // Fetch FSM, PC/credit counters and FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      req_q       <= 1'b0;
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          req_q <= credit_c;
        end
        FETCH, HOLD: begin
          state <= credit_c ? FETCH : HOLD;
          req_q <= credit_c;
        end
        default: begin
          state <= BOOT;
          req_q <= 1'b0;
        end
      endcase

      outstanding <= out_n_c;
      drop_cnt    <= drop_n_c;
      count       <= count_n_c;

      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc;
        ret_pc   <= bus.redirect_pc;
        rd_ptr   <= wr_ptr;
      end else begin
        if (issue_c) fetch_pc <= fetch_pc + 32'd1;
        if (live_c)  ret_pc   <= ret_pc + 32'd1;
        if (pop_c)   rd_ptr   <= rd_ptr + PTR_W'(1);
      end

      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

  // Prefetch FIFO storage; cleared so the idle head reads as pc 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
    end else if (push_c) begin
      fifo_q[wr_ptr] <= '{instr: bus.imem_rdata, pc: ret_pc};
    end
  end

  // Head selection: FIFO head, or the live response when it bypasses.
  always_comb begin
    head_c = fifo_q[rd_ptr];
    if (bypass_c) head_c = '{instr: bus.imem_rdata, pc: ret_pc};
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = fetch_pc;
  assign bus.id_valid    = (count != '0) | bypass_c;
  assign bus.id_instr    = head_c.instr;
  assign bus.id_pc       = head_c.pc;
  assign bus.id_pc_plus1 = head_c.pc + 32'd1;

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// tb_ifetch_prefetch_unit: scoreboard bench. The reference is the program-order
// stream a fetch unit must deliver: consecutive word PCs from RESET_PC, restarting
// at each redirect target, each carrying the memory's word for that address.
`timescale 1ns/1ps
module tb_ifetch_prefetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'd0;
`ifdef IFETCH_BYPASS_EN
  localparam int FILL_LAT = 2;
`else
  localparam int FILL_LAT = 3;
`endif

  logic clk = 1'b0;
  logic reset_n;

  ifetch_prefetch_unit_if bus();

  ifetch_prefetch_unit #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t  exp_q[$];
  mreq_t mq[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int gnt_mode = 0;   // 0: always grant, 1: never, 2: random
  int lat_mode = 1;   // 0: random 1..4, otherwise fixed latency

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic extend_stream();
    logic [31:0] p;
    if (exp_q.size() == 0) return;
    p = exp_q[$].pc;
    for (int i = 0; i < 64; i++) begin
      p = p + 32'd1;
      exp_q.push_back('{p, word_of(p)});
    end
  endtask

  task automatic start_stream(input logic [31:0] pc);
    exp_q.delete();
    exp_q.push_back('{pc, word_of(pc)});
    extend_stream();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    start_stream(pc);
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.id_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.id_valid !== 1'b1) n = 99;
  endtask

  // Instruction memory: in-order responses after a per-request latency.
  initial begin : mem_model
    int lat;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (bus.imem_rvalid === 1'b1) mq.delete(0);
        if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
          lat = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
          mq.push_back('{bus.imem_addr, cyc + lat});
        end
        check32("outstanding_bound", (mq.size() <= int'(MAX_OUT)) ? 32'd1 : 32'd0, 32'd1);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (reset_n !== 1'b1) mq.delete();
      case (gnt_mode)
        0:       bus.imem_gnt = 1'b1;
        1:       bus.imem_gnt = 1'b0;
        default: bus.imem_gnt = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      endcase
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word_of(mq[0].addr);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: request stability and in-order delivery against the scoreboard.
  initial begin : monitor
    logic        pend;
    logic [31:0] pend_addr;
    exp_t        e;
    pend      = 1'b0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check32("req_held", 32'(bus.imem_req), 32'd1);
          check32("addr_held", bus.imem_addr, pend_addr);
        end
        pend      = (bus.imem_req === 1'b1) && (bus.imem_gnt !== 1'b1) && (bus.redirect_valid !== 1'b1);
        pend_addr = bus.imem_addr;
        if (bus.id_valid === 1'b1 && bus.id_ready === 1'b1 && bus.redirect_valid !== 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: got id_pc 0x%08h expected no transfer", bus.id_pc);
          end else begin
            e = exp_q.pop_front();
            check32("id_pc", bus.id_pc, e.pc);
            check32("id_instr", bus.id_instr, e.instr);
            check32("id_pc_plus1", bus.id_pc_plus1, e.pc + 32'd1);
            if (exp_q.size() < 16) extend_stream();
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    reset_n            = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    start_stream(RESET_PC);
    repeat (3) tick();

    check32("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check32("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check32("rst_id_pc", bus.id_pc, 32'd0);
    check32("rst_id_pc_plus1", bus.id_pc_plus1, 32'd1);
    check32("rst_id_instr", bus.id_instr, 32'd0);

    // Release: BOOT cycle without request, then fetch from RESET_PC.
    reset_n = 1'b1;
    check32("boot_no_req", 32'(bus.imem_req), 32'd0);
    tick();
    check32("fetch_req", 32'(bus.imem_req), 32'd1);
    check32("fetch_addr", bus.imem_addr, RESET_PC);
    wait_valid(n);
    check32("fill_latency", 32'(n), 32'(FILL_LAT - 1));

    // Full throughput with zero-wait memory.
    repeat (16) begin
      tick();
      check32("throughput_valid", 32'(bus.id_valid), 32'd1);
    end

    // Decode stall: FIFO fills, requests stop, nothing is lost.
    bus.id_ready = 1'b0;
    repeat (10) tick();
    check32("stall_hold_req", 32'(bus.imem_req), 32'd0);
    check32("stall_valid", 32'(bus.id_valid), 32'd1);
    bus.id_ready = 1'b1;
    repeat (8) begin
      tick();
      check32("resume_valid", 32'(bus.id_valid), 32'd1);
    end

    // Redirect with two requests in flight (slow memory).
    lat_mode = 3;
    repeat (8) tick();
    redirect_to(32'h40);
    lat_mode = 1;
    repeat (12) tick();

    // Redirect coinciding with rvalid and gnt; flush and refill latency.
    repeat (6) tick();
    redirect_to(32'h80);
    check32("redirect_flush", 32'(bus.id_valid), 32'd0);
    wait_valid(n);
    check32("redirect_latency", 32'(n), 32'(FILL_LAT - 1));
    repeat (8) tick();

    // Ungranted request after redirect keeps its retargeted address.
    repeat (4) tick();
    gnt_mode = 1;
    redirect_to(32'h20);
    for (int i = 0; i < 5; i++) begin
      check32("retarget_req", 32'(bus.imem_req), 32'd1);
      check32("retarget_addr", bus.imem_addr, 32'h20);
      tick();
    end
    gnt_mode = 0;
    repeat (10) tick();

    // PC wrap-around.
    redirect_to(32'h7FFF_FFFE);
    repeat (8) tick();
    redirect_to(32'hFFFF_FFFE);
    repeat (10) tick();

    // Back-to-back redirects: the later target wins.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    start_stream(32'h100);
    tick();
    bus.redirect_pc = 32'h200;
    start_stream(32'h200);
    tick();
    bus.redirect_valid = 1'b0;
    repeat (12) tick();

    // Randomized traffic: grants, latency, decode stalls and redirects.
    gnt_mode = 2;
    lat_mode = 0;
    for (int i = 0; i < 800; i++) begin
      bus.id_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 24) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                                         : 32'($urandom);
        start_stream(bus.redirect_pc);
      end else begin
        bus.redirect_valid = 1'b0;
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    gnt_mode           = 0;
    lat_mode           = 1;
    repeat (12) tick();

    // Asynchronous reset in the middle of a stalled stream.
    bus.id_ready = 1'b0;
    repeat (2) tick();
    check32("pre_reset_valid", 32'(bus.id_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check32("async_rst_valid", 32'(bus.id_valid), 32'd0);
    check32("async_rst_req", 32'(bus.imem_req), 32'd0);
    check32("async_rst_pc", bus.id_pc, 32'd0);
    check32("async_rst_plus1", bus.id_pc_plus1, 32'd1);
    start_stream(RESET_PC);
    repeat (2) tick();
    reset_n      = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    check32("restart_addr", bus.imem_addr, RESET_PC);
    wait_valid(n);
    check32("restart_latency", 32'(n), 32'(FILL_LAT - 1));
    repeat (12) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
